exc_entry_ctrl: RTL and testbench
=================================

EXC_ENTRY_CTRL -- requirements
Module: exc_entry_ctrl

Interface
REQ-001 SHALL provide parameter VECTOR_BASE, default 32'h0000_0000, base address added to every exception vector offset.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports irq, fiq  input  1 each  external interrupt requests, level-high, asynchronous to clk.
REQ-005 SHALL have ports und_req, swi_req  input  1 each  undefined-instruction / SWI request from decode, synchronous.
REQ-006 SHALL have port instr_done  input  1  current instruction retires this cycle (instruction boundary).
REQ-007 SHALL have ports cpsr  input  32  current CPSR; pc_next  input  32  address of the next sequential instruction.
REQ-008 SHALL have outputs change_m  3, w_spsr_s  1, write_spsr  1, w_cpsr_s  3, write_cpsr  1  status-register control bus.
REQ-009 SHALL have outputs lr_value  32, write_lr  1, pc_vector  32, write_pc  1  link/PC writeback.
REQ-010 SHALL have outputs stall  1  freezes fetch/decode; exc_taken  1  one-cycle pulse; exc_type  2  captured cause (0 FIQ, 1 IRQ, 2 UND, 3 SWI).

Function
REQ-011 SHALL pass irq and fiq each through a 2-flop synchronizer; only synchronized values are used.
REQ-012 SHALL implement states IDLE, SAVE, SWITCH, LINK, VECTOR; one cycle each outside IDLE; VECTOR always returns to IDLE.
REQ-013 In IDLE, SHALL accept a request only when instr_done=1; priority FIQ (cpsr[6]=0) > IRQ (cpsr[7]=0) > UND > SWI.
REQ-014 A masked FIQ/IRQ SHALL be ignored, not latched; UND/SWI not coinciding with instr_done=1 SHALL be dropped.
REQ-015 On acceptance, SHALL capture exc_type and pc_next into internal registers and move to SAVE next cycle; later input changes SHALL not affect the sequence.
REQ-016 Change_m code per type SHALL be FIQ 1, IRQ 2, SVC(SWI) 3, UND 4; w_cpsr_s code per type SHALL be IRQ 2, FIQ 3, SVC 4, UND 5.
REQ-017 SAVE: write_spsr=1, w_spsr_s=1 (SPSR <- CPSR), change_m=target code.
REQ-018 SWITCH: write_cpsr=1, w_cpsr_s=target code, change_m=target code.
REQ-019 LINK: write_lr=1, change_m=target code; lr_value = captured pc +4 for FIQ/IRQ, = captured pc for UND/SWI (32-bit, wraps modulo 2^32).
REQ-020 VECTOR: write_pc=1, exc_taken=1, pc_vector = VECTOR_BASE + offset: UND 0x04, SWI 0x08, IRQ 0x18, FIQ 0x1C.
REQ-021 All control outputs SHALL be registered/Moore, stable for the whole cycle (consumer samples on falling edge).
REQ-022 Outside their named state, write_spsr, write_cpsr, write_lr, write_pc, exc_taken SHALL be 0; change_m, w_cpsr_s, w_spsr_s SHALL be 0.
REQ-023 stall SHALL be 1 in SAVE, SWITCH, LINK, VECTOR and 0 in IDLE.
REQ-024 exc_type SHALL hold the last captured cause until the next acceptance.
REQ-025 Accept-to-write_pc latency SHALL be exactly 4 cycles; a new request is acceptable in the cycle after VECTOR (back-to-back entry allowed).

Reset
REQ-026 clr=1 SHALL immediately force IDLE, clear synchronizers and capture registers, drive every output to 0, including mid-sequence.
REQ-027 After clr deasserts, SHALL accept no FIQ/IRQ before the synchronizer has seen 2 rising edges.

Verification
REQ-028 cpsr=0x10, irq held, instr_done=1, pc_next=0x100 -> SAVE/SWITCH(w_cpsr_s=2)/LINK(lr_value=0x104)/VECTOR(pc_vector=0x18), exc_type=1.
REQ-029 irq and fiq together, cpsr[7:6]=00 -> FIQ taken, w_cpsr_s=3, pc_vector=0x1C; with cpsr[6]=1 -> IRQ taken instead.
REQ-030 swi_req=1, instr_done=1, pc_next=0x200 -> change_m=3, w_cpsr_s=4, lr_value=0x200, pc_vector=0x08; with instr_done=0 -> no sequence.
REQ-031 und_req=1 and swi_req=1 same cycle -> UND taken, pc_vector=0x04, lr_value=pc_next.
REQ-032 clr pulsed during LINK -> next cycle all outputs 0, state IDLE, no write_pc.
REQ-033 pc_next=0xFFFF_FFFC, IRQ -> lr_value=0x0000_0000; VECTOR_BASE=0xFFFF_0000 -> pc_vector=0xFFFF_0018.

Source files
------------

// File: rtl/exc_entry_ctrl.sv
// Exception entry sequencer.
// Accepts FIQ/IRQ/UND/SWI at an instruction boundary, then steps through
// SAVE (SPSR <- CPSR), SWITCH (mode change), LINK (LR write) and VECTOR
// (PC redirect). It stalls fetch/decode for the four cycles of the sequence.
// Every control output comes straight from a flop, so it is stable for the
// whole cycle.

module exc_entry_ctrl #(
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        irq,
  input  logic        fiq,
  input  logic        und_req,
  input  logic        swi_req,
  input  logic        instr_done,
  input  logic [31:0] cpsr,
  input  logic [31:0] pc_next,
  output logic [2:0]  change_m,
  output logic        w_spsr_s,
  output logic        write_spsr,
  output logic [2:0]  w_cpsr_s,
  output logic        write_cpsr,
  output logic [31:0] lr_value,
  output logic        write_lr,
  output logic [31:0] pc_vector,
  output logic        write_pc,
  output logic        stall,
  output logic        exc_taken,
  output logic [1:0]  exc_type
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SAVE   = 3'd1;
  localparam logic [2:0] SWITCH = 3'd2;
  localparam logic [2:0] LINK   = 3'd3;
  localparam logic [2:0] VECTOR = 3'd4;

  localparam logic [1:0] EXC_FIQ = 2'd0;
  localparam logic [1:0] EXC_IRQ = 2'd1;
  localparam logic [1:0] EXC_UND = 2'd2;
  localparam logic [1:0] EXC_SWI = 2'd3;

  // Registered copy of every control output.
  typedef struct packed {
    logic [2:0]  change_m;
    logic        w_spsr_s;
    logic        write_spsr;
    logic [2:0]  w_cpsr_s;
    logic        write_cpsr;
    logic [31:0] lr_value;
    logic        write_lr;
    logic [31:0] pc_vector;
    logic        write_pc;
    logic        stall;
    logic        exc_taken;
  } ctrl_t;

  logic [2:0]  state_q, state_d;
  logic [1:0]  type_q, type_d;
  logic [31:0] pc_q;
  logic        accept;
  logic        irq_s1, irq_s2, fiq_s1, fiq_s2;
  ctrl_t       ctrl_q, ctrl_d;

  // Only the I and F mask bits of the CPSR matter here.
  logic unused_cpsr;
  assign unused_cpsr = ^{cpsr[31:8], cpsr[5:0]};

  // Mode code driven on change_m for each cause.
  function automatic logic [2:0] mode_code(input logic [1:0] t);
    case (t)
      EXC_FIQ: mode_code = 3'd1;
      EXC_IRQ: mode_code = 3'd2;
      EXC_SWI: mode_code = 3'd3;
      default: mode_code = 3'd4;
    endcase
  endfunction

  // CPSR source select driven on w_cpsr_s for each cause.
  function automatic logic [2:0] cpsr_code(input logic [1:0] t);
    case (t)
      EXC_IRQ: cpsr_code = 3'd2;
      EXC_FIQ: cpsr_code = 3'd3;
      EXC_SWI: cpsr_code = 3'd4;
      default: cpsr_code = 3'd5;
    endcase
  endfunction

  // Vector table offset for each cause.
  function automatic logic [31:0] vec_offset(input logic [1:0] t);
    case (t)
      EXC_UND: vec_offset = 32'h04;
      EXC_SWI: vec_offset = 32'h08;
      EXC_IRQ: vec_offset = 32'h18;
      default: vec_offset = 32'h1C;
    endcase
  endfunction

  // Two-flop synchronizers for the asynchronous interrupt lines.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      irq_s1 <= 1'b0;
      irq_s2 <= 1'b0;
      fiq_s1 <= 1'b0;
      fiq_s2 <= 1'b0;
    end else begin
      irq_s1 <= irq;
      irq_s2 <= irq_s1;
      fiq_s1 <= fiq;
      fiq_s2 <= fiq_s1;
    end
  end

  // Prioritised acceptance at an instruction boundary, then the fixed walk.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_done) begin
          if (fiq_s2 && !cpsr[6]) begin
            accept = 1'b1;
            type_d = EXC_FIQ;
          end else if (irq_s2 && !cpsr[7]) begin
            accept = 1'b1;
            type_d = EXC_IRQ;
          end else if (und_req) begin
            accept = 1'b1;
            type_d = EXC_UND;
          end else if (swi_req) begin
            accept = 1'b1;
            type_d = EXC_SWI;
          end
        end
        if (accept) state_d = SAVE;
      end
      SAVE:    state_d = SWITCH;
      SWITCH:  state_d = LINK;
      LINK:    state_d = VECTOR;
      default: state_d = IDLE;
    endcase
  end

  // Outputs for the upcoming state, so the flops present them for that whole cycle.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      SAVE: begin
        ctrl_d.stall      = 1'b1;
        ctrl_d.write_spsr = 1'b1;
        ctrl_d.w_spsr_s   = 1'b1;
        ctrl_d.change_m   = mode_code(type_d);
      end
      SWITCH: begin
        ctrl_d.stall      = 1'b1;
        ctrl_d.write_cpsr = 1'b1;
        ctrl_d.w_cpsr_s   = cpsr_code(type_d);
        ctrl_d.change_m   = mode_code(type_d);
      end
      LINK: begin
        ctrl_d.stall    = 1'b1;
        ctrl_d.write_lr = 1'b1;
        ctrl_d.change_m = mode_code(type_d);
        ctrl_d.lr_value = (type_d == EXC_FIQ || type_d == EXC_IRQ) ? pc_q + 32'd4 : pc_q;
      end
      VECTOR: begin
        ctrl_d.stall     = 1'b1;
        ctrl_d.write_pc  = 1'b1;
        ctrl_d.exc_taken = 1'b1;
        ctrl_d.pc_vector = VECTOR_BASE + vec_offset(type_d);
      end
      default: ctrl_d = '0;
    endcase
  end

  // State, captured cause/PC and registered outputs.
  // NOTE: the capture registers are reset too, so a cleared controller never exposes stale cause or PC.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      type_q  <= 2'd0;
      pc_q    <= 32'd0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      if (accept) pc_q <= pc_next;
      ctrl_q  <= ctrl_d;
    end
  end

  assign change_m   = ctrl_q.change_m;
  assign w_spsr_s   = ctrl_q.w_spsr_s;
  assign write_spsr = ctrl_q.write_spsr;
  assign w_cpsr_s   = ctrl_q.w_cpsr_s;
  assign write_cpsr = ctrl_q.write_cpsr;
  assign lr_value   = ctrl_q.lr_value;
  assign write_lr   = ctrl_q.write_lr;
  assign pc_vector  = ctrl_q.pc_vector;
  assign write_pc   = ctrl_q.write_pc;
  assign stall      = ctrl_q.stall;
  assign exc_taken  = ctrl_q.exc_taken;
  assign exc_type   = type_q;

endmodule

// File: tb/tb_exc_entry_ctrl.sv
// Directed bench for exc_entry_ctrl: reset, each exception cause, priority,
// masking, dropped requests, mid-sequence clear, PC wrap and back-to-back entry.
// A second instance with a high VECTOR_BASE checks the base addition.

module tb_exc_entry_ctrl;

  // {stall, write_spsr, w_spsr_s, write_cpsr, w_cpsr_s, change_m, write_lr,
  //  lr_value, write_pc, exc_taken, pc_vector, exc_type}
  typedef logic [78:0] bus_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        irq = 1'b0, fiq = 1'b0, und_req = 1'b0, swi_req = 1'b0, instr_done = 1'b0;
  logic [31:0] cpsr = 32'h10, pc_next = 32'h0;

  logic [2:0]  change_m, w_cpsr_s;
  logic        w_spsr_s, write_spsr, write_cpsr, write_lr, write_pc, stall, exc_taken;
  logic [31:0] lr_value, pc_vector;
  logic [1:0]  exc_type;

  logic [2:0]  h_change_m, h_w_cpsr_s;
  logic        h_w_spsr_s, h_write_spsr, h_write_cpsr, h_write_lr, h_write_pc, h_stall, h_exc_taken;
  logic [31:0] h_lr_value, h_pc_vector;
  logic [1:0]  h_exc_type;

  int   checks   = 0;
  int   failures = 0;
  bus_t seen [0:4];
  logic [31:0] seen_hi_vec;

  always #5 clk = ~clk;

  exc_entry_ctrl dut (
    .clk(clk), .clr(clr), .irq(irq), .fiq(fiq), .und_req(und_req), .swi_req(swi_req),
    .instr_done(instr_done), .cpsr(cpsr), .pc_next(pc_next),
    .change_m(change_m), .w_spsr_s(w_spsr_s), .write_spsr(write_spsr),
    .w_cpsr_s(w_cpsr_s), .write_cpsr(write_cpsr), .lr_value(lr_value),
    .write_lr(write_lr), .pc_vector(pc_vector), .write_pc(write_pc),
    .stall(stall), .exc_taken(exc_taken), .exc_type(exc_type)
  );

  exc_entry_ctrl #(.VECTOR_BASE(32'hFFFF_0000)) dut_hi (
    .clk(clk), .clr(clr), .irq(irq), .fiq(fiq), .und_req(und_req), .swi_req(swi_req),
    .instr_done(instr_done), .cpsr(cpsr), .pc_next(pc_next),
    .change_m(h_change_m), .w_spsr_s(h_w_spsr_s), .write_spsr(h_write_spsr),
    .w_cpsr_s(h_w_cpsr_s), .write_cpsr(h_write_cpsr), .lr_value(h_lr_value),
    .write_lr(h_write_lr), .pc_vector(h_pc_vector), .write_pc(h_write_pc),
    .stall(h_stall), .exc_taken(h_exc_taken), .exc_type(h_exc_type)
  );

  function automatic bus_t obs();
    return {stall, write_spsr, w_spsr_s, write_cpsr, w_cpsr_s, change_m, write_lr,
            lr_value, write_pc, exc_taken, pc_vector, exc_type};
  endfunction

  // Expected output bus for one phase of an entry (0 = IDLE, 1..4 = SAVE..VECTOR).
  function automatic bus_t exp_bus(input int phase, input logic [1:0] t, input logic [2:0] cm,
                                   input logic [2:0] wcs, input logic [31:0] lr,
                                   input logic [31:0] vec);
    case (phase)
      1:       return {1'b1, 1'b1, 1'b1, 1'b0, 3'd0, cm, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, t};
      2:       return {1'b1, 1'b0, 1'b0, 1'b1, wcs, cm, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, t};
      3:       return {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, cm, 1'b1, lr, 1'b0, 1'b0, 32'd0, t};
      4:       return {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 32'd0, 1'b1, 1'b1, vec, t};
      default: return {1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, t};
    endcase
  endfunction

  // Presents a request, lets the synchronizers settle, raises instr_done for
  // one cycle, then scrambles the inputs and records SAVE..VECTOR and the IDLE after.
  task automatic run_entry(input logic irq_v, input logic fiq_v, input logic und_v,
                           input logic swi_v, input logic [31:0] cpsr_v, input logic [31:0] pc_v);
    @(negedge clk);
    irq = irq_v; fiq = fiq_v; und_req = und_v; swi_req = swi_v;
    cpsr = cpsr_v; pc_next = pc_v; instr_done = 1'b0;
    repeat (2) @(negedge clk);
    instr_done = 1'b1;
    @(negedge clk);
    seen[1] = obs();
    irq = 1'b0; fiq = 1'b0; und_req = 1'b0; swi_req = 1'b0; instr_done = 1'b0;
    pc_next = 32'hDEAD_BEEF; cpsr = 32'hFFFF_FFFF;
    for (int p = 2; p <= 4; p++) begin
      @(negedge clk);
      seen[p] = obs();
    end
    seen_hi_vec = h_pc_vector;
    @(negedge clk);
    seen[0] = obs();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected %h", obs(), bus_t'(0));
    end
    irq = 1'b1; instr_done = 1'b1; cpsr = 32'h10; pc_next = 32'h100;
    clr = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (stall !== (c == 3)) begin
        failures++;
        $display("FAIL reset_sync_delay cycle %0d: stall got %b expected %b", c, stall, c == 3);
      end
    end
    irq = 1'b0; instr_done = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_irq();
    bus_t e;
    run_entry(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h100);
    for (int p = 0; p <= 4; p++) begin
      e = exp_bus(p, 2'd1, 3'd2, 3'd2, 32'h104, 32'h18);
      checks++;
      if (seen[p] !== e) begin
        failures++;
        $display("FAIL irq phase %0d: got %h expected %h", p, seen[p], e);
      end
    end
    checks++;
    if (seen_hi_vec !== 32'hFFFF_0018) begin
      failures++;
      $display("FAIL irq_vector_base: got %h expected %h", seen_hi_vec, 32'hFFFF_0018);
    end
  endtask

  task automatic test_fiq_priority();
    bus_t e;
    run_entry(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h300);
    for (int p = 0; p <= 4; p++) begin
      e = exp_bus(p, 2'd0, 3'd1, 3'd3, 32'h304, 32'h1C);
      checks++;
      if (seen[p] !== e) begin
        failures++;
        $display("FAIL fiq_over_irq phase %0d: got %h expected %h", p, seen[p], e);
      end
    end
    run_entry(1'b1, 1'b1, 1'b0, 1'b0, 32'h50, 32'h340);
    for (int p = 0; p <= 4; p++) begin
      e = exp_bus(p, 2'd1, 3'd2, 3'd2, 32'h344, 32'h18);
      checks++;
      if (seen[p] !== e) begin
        failures++;
        $display("FAIL fiq_masked_irq phase %0d: got %h expected %h", p, seen[p], e);
      end
    end
  endtask

  task automatic test_swi();
    bus_t e;
    run_entry(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h200);
    for (int p = 0; p <= 4; p++) begin
      e = exp_bus(p, 2'd3, 3'd3, 3'd4, 32'h200, 32'h08);
      checks++;
      if (seen[p] !== e) begin
        failures++;
        $display("FAIL swi phase %0d: got %h expected %h", p, seen[p], e);
      end
    end
    // Without an instruction boundary the request is dropped.
    swi_req = 1'b1; und_req = 1'b1; instr_done = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || write_pc !== 1'b0) begin
        failures++;
        $display("FAIL swi_no_boundary cycle %0d: stall %b write_pc %b expected 0 0", c, stall, write_pc);
      end
    end
    swi_req = 1'b0; und_req = 1'b0;
  endtask

  task automatic test_und_priority();
    bus_t e;
    run_entry(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h400);
    for (int p = 0; p <= 4; p++) begin
      e = exp_bus(p, 2'd2, 3'd4, 3'd5, 32'h400, 32'h04);
      checks++;
      if (seen[p] !== e) begin
        failures++;
        $display("FAIL und_over_swi phase %0d: got %h expected %h", p, seen[p], e);
      end
    end
  endtask

  task automatic test_masked();
    cpsr = 32'hD0; irq = 1'b1; fiq = 1'b1; instr_done = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin
        failures++;
        $display("FAIL masked_ignored cycle %0d: stall got %b expected 0", c, stall);
      end
    end
    irq = 1'b0; fiq = 1'b0; instr_done = 1'b0;
    repeat (3) @(negedge clk);
    cpsr = 32'h10; instr_done = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin
        failures++;
        $display("FAIL masked_not_latched cycle %0d: stall got %b expected 0", c, stall);
      end
    end
    instr_done = 1'b0;
  endtask

  task automatic test_lr_wrap();
    bus_t e;
    run_entry(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'hFFFF_FFFC);
    for (int p = 1; p <= 4; p++) begin
      e = exp_bus(p, 2'd1, 3'd2, 3'd2, 32'h0, 32'h18);
      checks++;
      if (seen[p] !== e) begin
        failures++;
        $display("FAIL lr_wrap phase %0d: got %h expected %h", p, seen[p], e);
      end
    end
  endtask

  task automatic test_clr_mid();
    bus_t e;
    @(negedge clk);
    irq = 1'b1; cpsr = 32'h10; pc_next = 32'h700;
    repeat (2) @(negedge clk);
    instr_done = 1'b1;
    @(negedge clk);
    irq = 1'b0; instr_done = 1'b0;
    repeat (2) @(negedge clk);
    e = exp_bus(3, 2'd1, 3'd2, 3'd2, 32'h704, 32'h18);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL clr_mid_link: got %h expected %h", obs(), e);
    end
    #1 clr = 1'b1;
    #1;
    checks++;
    if (obs() !== '0) begin
      failures++;
      $display("FAIL clr_async: got %h expected %h", obs(), bus_t'(0));
    end
    #1 clr = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++;
      if (obs() !== '0) begin
        failures++;
        $display("FAIL clr_after cycle %0d: got %h expected %h", c, obs(), bus_t'(0));
      end
    end
  endtask

  task automatic test_back_to_back();
    bus_t e;
    int   ph;
    @(negedge clk);
    swi_req = 1'b1; instr_done = 1'b1; cpsr = 32'h10; pc_next = 32'h500;
    for (int s = 1; s <= 9; s++) begin
      @(negedge clk);
      ph = (s <= 4) ? s : (s == 5) ? 0 : s - 5;
      e  = exp_bus(ph, 2'd3, 3'd3, 3'd4, (s <= 4) ? 32'h500 : 32'h600, 32'h08);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL back_to_back step %0d: got %h expected %h", s, obs(), e);
      end
      if (s == 4) pc_next = 32'h600;
      if (s == 9) begin
        swi_req = 1'b0; instr_done = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_irq();
    test_fiq_priority();
    test_swi();
    test_und_priority();
    test_masked();
    test_lr_wrap();
    test_clr_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
